seq_div: RTL and testbench

// - Sequential restoring divider; computes one quotient bit per clock. It is the inverse companion of seq_mult.
// - Accepts an unsigned dividend/divisor pair over a valid/ready handshake.
// - Returns the quotient, the remainder and a divide-by-zero flag, with a one-cycle z_valid pulse.
// - Sits alongside seq_mult in the arithmetic datapath. Area-cheap, not throughput-critical.

---
 rtl/seq_div_pkg.sv | 22 ++
 rtl/seq_div_step.sv | 22 ++
 rtl/seq_div.sv | 114 +++++++++++
 tb/tb_seq_div.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIVIDEND_LEN_DEF = 8;
  localparam int CNT_W            = $clog2(DIVIDEND_LEN_DEF + 1);

  // Edges from acceptance to the result edge for a non-zero divisor.
  function automatic int div_latency(input int dividend_len);
    return dividend_len + 1;
  endfunction

  function automatic int cnt_width(input int dividend_len);
    return $clog2(dividend_len + 1);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module seq_div_step #(
  parameter int Divisor_length = 4
) (
  input  logic [Divisor_length:0]   rem_i,
  input  logic                      bit_i,
  input  logic [Divisor_length-1:0] div_i,
  output logic [Divisor_length:0]   rem_o,
  output logic                      qbit_o
);

  localparam int RW = Divisor_length + 1;

  // Keeping the full partial remainder in the shift means the compare is exact
  // even if the top remainder bit were ever set.
  logic [Divisor_length+1:0] shifted;

  assign shifted = {rem_i, bit_i};
  assign qbit_o  = (shifted >= {2'b00, div_i});
  assign rem_o   = qbit_o ? RW'(shifted - {2'b00, div_i}) : shifted[Divisor_length:0];

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned divider: one quotient bit per clock, valid/ready in, pulsed result out.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int Dividend_length = 8,
  parameter int Divisor_length  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [Dividend_length-1:0] a,
  input  logic [Divisor_length-1:0]  b,
  input  logic                       ab_valid,
  output logic                       ab_ready,
  output logic                       z_valid,
  output logic [Dividend_length-1:0] q,
  output logic [Divisor_length-1:0]  r,
  output logic                       dbz
);

  localparam int CNT_WIDTH = cnt_width(Dividend_length);

  state_t                     state_q;
  logic [Dividend_length-1:0] dq_q;
  logic [Divisor_length:0]    rem_q;
  logic [Divisor_length-1:0]  b_q;
  logic [CNT_WIDTH-1:0]       cnt_q;
  logic [Dividend_length-1:0] q_q;
  logic [Divisor_length-1:0]  r_q;
  logic                       dbz_q;
  logic                       z_valid_q;
  logic                       ab_ready_q;

  logic [Divisor_length:0]    rem_d;
  logic                       qbit_d;
  logic [Dividend_length-1:0] dq_d;
  logic                       accept;

  seq_div_step #(
    .Divisor_length(Divisor_length)
  ) u_step (
    .rem_i (rem_q),
    .bit_i (dq_q[Dividend_length-1]),
    .div_i (b_q),
    .rem_o (rem_d),
    .qbit_o(qbit_d)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign dq_d   = (dq_q << 1) | Dividend_length'(qbit_d);
  assign accept = ab_valid & ab_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dq_q       <= '0;
      rem_q      <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      dbz_q      <= 1'b0;
      z_valid_q  <= 1'b0;
      ab_ready_q <= 1'b1;
    end else begin
      z_valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q    <= IDLE;
          ab_ready_q <= 1'b1;
          if (accept) begin
            if (b != '0) begin
              dq_q       <= a;
              rem_q      <= '0;
              b_q        <= b;
              cnt_q      <= CNT_WIDTH'(Dividend_length);
              state_q    <= RUN;
              ab_ready_q <= 1'b0;
            end else begin
              q_q       <= '1;
              r_q       <= '0;
              dbz_q     <= 1'b1;
              z_valid_q <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        RUN: begin
          dq_q  <= dq_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            q_q        <= dq_d;
            r_q        <= rem_d[Divisor_length-1:0];
            dbz_q      <= 1'b0;
            z_valid_q  <= 1'b1;
            ab_ready_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        default: begin
          state_q    <= IDLE;
          ab_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ab_ready = ab_ready_q;
  assign z_valid  = z_valid_q;
  assign q        = q_q;
  assign r        = r_q;
  assign dbz      = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed vectors, back-to-back and reset corners, exhaustive shuffled sweep.
module tb_seq_div;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [3:0] b;
  logic       ab_valid;
  logic       ab_ready;
  logic       z_valid;
  logic [7:0] q;
  logic [3:0] r;
  logic       dbz;

  int passed;
  int total;

  seq_div #(
    .Dividend_length(8),
    .Divisor_length (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .ab_valid(ab_valid),
    .ab_ready(ab_ready),
    .z_valid (z_valid),
    .q       (q),
    .r       (r),
    .dbz     (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and waits (bounded) for its result pulse.
  task automatic run_op(input logic [7:0] ta, input logic [3:0] tbv,
                        output logic [7:0] got_q, output logic [3:0] got_r,
                        output logic got_dbz, output int lat, output int busy);
    int w;
    a        = ta;
    b        = tbv;
    ab_valid = 1'b1;
    w = 0;
    while (!ab_ready && w < 50) begin
      tick();
      w++;
    end
    tick();
    ab_valid = 1'b0;
    a        = $urandom_range(0, 255);
    b        = $urandom_range(0, 15);
    lat  = 1;
    busy = 0;
    while (!z_valid && lat < 40) begin
      if (!ab_ready) busy++;
      tick();
      lat++;
    end
    got_q   = q;
    got_r   = r;
    got_dbz = dbz;
  endtask

  initial begin
    logic [7:0] gq;
    logic [3:0] gr;
    logic       gd;
    int         lat;
    int         busy;
    int         gap;
    int         pulses;
    int         order[4096];

    passed   = 0;
    total    = 0;
    rst      = 1'b1;
    ab_valid = 1'b0;
    a        = '0;
    b        = '0;

    vecs[0] = '{a: 8'd100, b: 4'd7,  q: 8'd14,  r: 4'd2, dbz: 1'b0, lat: 9};
    vecs[1] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0, dbz: 1'b0, lat: 9};
    vecs[2] = '{a: 8'd5,   b: 4'd15, q: 8'd0,   r: 4'd5, dbz: 1'b0, lat: 9};
    vecs[3] = '{a: 8'd0,   b: 4'd9,  q: 8'd0,   r: 4'd0, dbz: 1'b0, lat: 9};
    vecs[4] = '{a: 8'd42,  b: 4'd0,  q: 8'hFF,  r: 4'd0, dbz: 1'b1, lat: 1};
    vecs[5] = '{a: 8'd9,   b: 4'd3,  q: 8'd3,   r: 4'd0, dbz: 1'b0, lat: 9};

    tick();
    tick();
    check("reset_ab_ready", int'(ab_ready), 1);
    check("reset_z_valid", int'(z_valid), 0);
    check("reset_q", int'(q), 0);
    check("reset_r", int'(r), 0);
    check("reset_dbz", int'(dbz), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, gq, gr, gd, lat, busy);
      $display("vec %0d: a=%0d b=%0d -> q=%0d r=%0d dbz=%0d lat=%0d busy=%0d",
               i, vecs[i].a, vecs[i].b, gq, gr, gd, lat, busy);
      check($sformatf("vec%0d_q", i), int'(gq), int'(vecs[i].q));
      check($sformatf("vec%0d_r", i), int'(gr), int'(vecs[i].r));
      check($sformatf("vec%0d_dbz", i), int'(gd), int'(vecs[i].dbz));
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      if (i == 0) check("vec0_ready_low_cycles", busy, 8);
      tick();
    end

    // Back-to-back: ab_valid stays high, the second op is taken in the first DONE cycle.
    a        = 8'd200;
    b        = 4'd13;
    ab_valid = 1'b1;
    tick();
    a   = 8'd77;
    b   = 4'd6;
    lat = 1;
    while (!z_valid && lat < 40) begin
      tick();
      lat++;
    end
    $display("b2b first: q=%0d r=%0d lat=%0d ready=%0d", q, r, lat, ab_ready);
    check("b2b_first_q", int'(q), 15);
    check("b2b_first_r", int'(r), 5);
    check("b2b_first_ready", int'(ab_ready), 1);
    tick();
    ab_valid = 1'b0;
    gap = 1;
    while (!z_valid && gap < 40) begin
      tick();
      gap++;
    end
    $display("b2b second: q=%0d r=%0d gap=%0d", q, r, gap);
    check("b2b_second_q", int'(q), 12);
    check("b2b_second_r", int'(r), 5);
    check("b2b_gap", gap, 9);
    tick();

    // Reset on the third RUN edge aborts the operation silently.
    a        = 8'd100;
    b        = 4'd7;
    ab_valid = 1'b1;
    tick();
    ab_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("mid-run reset: ready=%0d z_valid=%0d q=%0d r=%0d dbz=%0d", ab_ready, z_valid, q, r, dbz);
    check("abort_ab_ready", int'(ab_ready), 1);
    check("abort_z_valid", int'(z_valid), 0);
    check("abort_q", int'(q), 0);
    check("abort_r", int'(r), 0);
    check("abort_dbz", int'(dbz), 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (z_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);

    // Every (a,b) pair in shuffled order, checked against plain integer division.
    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 4096; i++) begin
      int ea;
      int eb;
      int eq;
      int er;
      int ed;
      int el;
      int gaps;
      ea = order[i] / 16;
      eb = order[i] % 16;
      if (eb == 0) begin
        eq = 255; er = 0; ed = 1; el = 1;
      end else begin
        eq = ea / eb; er = ea % eb; ed = 0; el = 9;
      end
      run_op(8'(ea), 4'(eb), gq, gr, gd, lat, busy);
      total++;
      if (int'(gq) == eq && int'(gr) == er && int'(gd) == ed && lat == el &&
          (ed == 1 || (int'(gq) * eb + int'(gr) == ea && int'(gr) < eb))) begin
        passed++;
        $display("sweep a=%0d b=%0d -> q=%0d r=%0d dbz=%0d lat=%0d", ea, eb, gq, gr, gd, lat);
      end else begin
        $display("FAIL sweep a=%0d b=%0d: got q=%0d r=%0d dbz=%0d lat=%0d expected q=%0d r=%0d dbz=%0d lat=%0d",
                 ea, eb, gq, gr, gd, lat, eq, er, ed, el);
      end
      gaps = $urandom_range(0, 2);
      for (int k = 0; k < gaps; k++) tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
